// File: rtl/cipher_pkg.sv
// Shared IDEA definitions: word sizes and the 16-bit arithmetic primitives
// used by both the encryptor and the decryptor.
package cipher_pkg;

    localparam int WORD     = 16;
    localparam int BLOCK    = 64;
    localparam int KEYW     = 128;
    localparam int NSUBKEYS = 52;
    localparam int ROUNDS   = 8;

    // Multiplication mod 65537; the all-zero word stands for 65536.
    function automatic logic [WORD-1:0] idea_mul(input logic [WORD-1:0] a,
                                                 input logic [WORD-1:0] b);
        logic [16:0] op_a;
        logic [16:0] op_b;
        logic [33:0] prod;
        logic [33:0] rem;
        op_a = (a == '0) ? 17'h10000 : {1'b0, a};
        op_b = (b == '0) ? 17'h10000 : {1'b0, b};
        prod = op_a * op_b;
        rem  = prod % 34'd65537;
        // A residue of 65536 drops its bit 16 and encodes as 0.
        return rem[WORD-1:0];
    endfunction

    function automatic logic [WORD-1:0] idea_add(input logic [WORD-1:0] a,
                                                 input logic [WORD-1:0] b);
        return a + b;
    endfunction

    // Subkey idx (0-based, so Z1 is idx 0): every group of eight subkeys
    // comes from the key rotated left by a further 25 bits.
    function automatic logic [WORD-1:0] idea_subkey(input logic [KEYW-1:0] k,
                                                    input int idx);
        int             grp;
        int             pos;
        int             sh;
        logic [KEYW-1:0] rot;
        grp = idx / 8;
        pos = idx % 8;
        sh  = (25 * grp) % KEYW;
        rot = (sh == 0) ? k : ((k << sh) | (k >> (KEYW - sh)));
        return rot[KEYW-1-WORD*pos -: WORD];
    endfunction

endpackage

// File: rtl/idea_round.sv
// One full IDEA round, purely combinational. subkeys[0] is the first subkey
// of the round (Z1 for round 1).
module idea_round
    import cipher_pkg::*;
(
    input  logic [BLOCK-1:0]      block_in,
    input  logic [5:0][WORD-1:0]  subkeys,
    output logic [BLOCK-1:0]      block_out
);

    logic [WORD-1:0] a, b, c, d, e, f, t0, t1, t2;

    // Multiply-add structure; middle output words are swapped.
    always_comb begin
        a  = idea_mul(block_in[63:48], subkeys[0]);
        b  = idea_add(block_in[47:32], subkeys[1]);
        c  = idea_add(block_in[31:16], subkeys[2]);
        d  = idea_mul(block_in[15:0],  subkeys[3]);
        e  = a ^ c;
        f  = b ^ d;
        t0 = idea_mul(e, subkeys[4]);
        t2 = idea_mul(idea_add(f, t0), subkeys[5]);
        t1 = idea_add(t0, t2);
        block_out = {a ^ t2, c ^ t2, b ^ t1, d ^ t1};
    end

endmodule

// File: rtl/idea_sync_encryptor.sv
// Iterative IDEA encryptor: one round per enabled clock, then the output
// transformation, giving a result 9 enabled cycles after accept.
module idea_sync_encryptor
    import cipher_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              start,
    input  logic [BLOCK-1:0]  inBlock64,
    input  logic [KEYW-1:0]   key,
    output logic [BLOCK-1:0]  outBlock64,
    output logic              busy,
    output logic              valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    logic [1:0]             state;
    logic [3:0]             round_cnt;
    logic [BLOCK-1:0]       data;
    logic [KEYW-1:0]        key_reg;
    logic [WORD-1:0]        subkeys [NSUBKEYS];
    logic [5:0][WORD-1:0]   round_keys;
    logic [BLOCK-1:0]       round_out;
    logic [BLOCK-1:0]       final_block;
    logic [5:0]             key_base;

    // Expand the latched key into all 52 subkeys.
    always_comb begin
        for (int i = 0; i < NSUBKEYS; i++) begin
            subkeys[i] = idea_subkey(key_reg, i);
        end
    end

    // Select the six subkeys of the current round.
    always_comb begin
        round_keys = '0;
        key_base   = 6'(round_cnt) * 6'd6;
        if (round_cnt < 4'(ROUNDS)) begin
            for (int i = 0; i < 6; i++) begin
                round_keys[i] = subkeys[key_base + 6'(i)];
            end
        end
    end

    idea_round u_round (
        .block_in  (data),
        .subkeys   (round_keys),
        .block_out (round_out)
    );

    // Output transformation; undoes the middle-word swap of the last round.
    always_comb begin
        final_block = {idea_mul(data[63:48], subkeys[48]),
                       idea_add(data[31:16], subkeys[49]),
                       idea_add(data[47:32], subkeys[50]),
                       idea_mul(data[15:0],  subkeys[51])};
    end

    // Sequencer: accept, eight rounds, output transform. ena freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            round_cnt  <= '0;
            data       <= '0;
            key_reg    <= '0;
            outBlock64 <= '0;
            busy       <= 1'b0;
            valid      <= 1'b0;
        end else if (ena) begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        data      <= inBlock64;
                        key_reg   <= key;
                        round_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    data      <= round_out;
                    round_cnt <= round_cnt + 4'd1;
                    if (round_cnt == 4'(ROUNDS - 1)) begin
                        state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    outBlock64 <= final_block;
                    valid      <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idea_sync_encryptor.sv
// Scoreboard bench for idea_sync_encryptor: the stimulus side queues the
// expected ciphertext and completion cycle, the monitor checks each valid.
module tb_idea_sync_encryptor;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          start;
    logic [63:0]   inBlock64;
    logic [127:0]  key;
    logic [63:0]   outBlock64;
    logic          busy;
    logic          valid;

    idea_sync_encryptor dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .start      (start),
        .inBlock64  (inBlock64),
        .key        (key),
        .outBlock64 (outBlock64),
        .busy       (busy),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KAT_KEY = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    localparam logic [63:0]  KAT_PT  = 64'h0000_0001_0002_0003;
    localparam logic [63:0]  KAT_CT  = 64'h11FB_ED2B_0198_6DE5;

    typedef logic [15:0] sk_t [52];
    typedef struct {
        logic [63:0]  ct;
        int           cyc;
        logic [63:0]  pt;
        logic [127:0] k;
        bit           rt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   pushed = 0;
    int   cyc    = 0;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
        longint x, y, r;
        x = (a == 16'h0) ? 64'd65536 : longint'(a);
        y = (b == 16'h0) ? 64'd65536 : longint'(b);
        r = (x * y) % 65537;
        return (r == 65536) ? 16'h0 : r[15:0];
    endfunction

    function automatic logic [15:0] m_inv(input logic [15:0] a);
        longint base, res, e;
        base = (a == 16'h0) ? 64'd65536 : longint'(a);
        res  = 1;
        e    = 65535;
        while (e > 0) begin
            if (e[0]) res = (res * base) % 65537;
            base = (base * base) % 65537;
            e    = e >> 1;
        end
        return (res == 65536) ? 16'h0 : res[15:0];
    endfunction

    function automatic void m_schedule(input logic [127:0] k_in, output sk_t z);
        logic [127:0] k;
        int n;
        k = k_in;
        n = 0;
        while (n < 52) begin
            for (int j = 0; j < 8; j++) begin
                if (n < 52) begin
                    z[n] = k[127-16*j -: 16];
                    n++;
                end
            end
            k = {k[102:0], k[127:103]};
        end
    endfunction

    function automatic logic [63:0] m_cipher(input logic [63:0] blk, input sk_t z);
        logic [15:0] x1, x2, x3, x4, a, b, c, d, e, f, t0, t1, t2, s, y2, y3;
        x1 = blk[63:48]; x2 = blk[47:32]; x3 = blk[31:16]; x4 = blk[15:0];
        for (int r = 0; r < 8; r++) begin
            a  = m_mul(x1, z[6*r]);
            b  = x2 + z[6*r+1];
            c  = x3 + z[6*r+2];
            d  = m_mul(x4, z[6*r+3]);
            e  = a ^ c;
            f  = b ^ d;
            t0 = m_mul(e, z[6*r+4]);
            s  = f + t0;
            t2 = m_mul(s, z[6*r+5]);
            t1 = t0 + t2;
            x1 = a ^ t2; x2 = c ^ t2; x3 = b ^ t1; x4 = d ^ t1;
        end
        y2 = x3 + z[49];
        y3 = x2 + z[50];
        return {m_mul(x1, z[48]), y2, y3, m_mul(x4, z[51])};
    endfunction

    function automatic logic [63:0] m_enc(input logic [63:0] pt, input logic [127:0] k);
        sk_t ek;
        m_schedule(k, ek);
        return m_cipher(pt, ek);
    endfunction

    // Decryption with inverted subkeys, independent of the forward path.
    function automatic logic [63:0] m_dec(input logic [63:0] ct, input logic [127:0] k);
        sk_t ek, dk;
        m_schedule(k, ek);
        for (int r = 0; r < 9; r++) begin
            dk[6*r]   = m_inv(ek[48-6*r]);
            dk[6*r+3] = m_inv(ek[51-6*r]);
            if (r == 0 || r == 8) begin
                dk[6*r+1] = -ek[49-6*r];
                dk[6*r+2] = -ek[50-6*r];
            end else begin
                dk[6*r+1] = -ek[50-6*r];
                dk[6*r+2] = -ek[49-6*r];
            end
            if (r < 8) begin
                dk[6*r+4] = ek[46-6*r];
                dk[6*r+5] = ek[47-6*r];
            end
        end
        return m_cipher(ct, dk);
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        if (valid === 1'b1) begin
            exp_t e;
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=%h at cycle %0d required=no pulse",
                         outBlock64, cyc);
            end else begin
                e = sb.pop_front();
                chk("ciphertext", outBlock64, e.ct);
                chk("valid_cycle", cyc, e.cyc);
                if (e.rt) chk("roundtrip", m_dec(outBlock64, e.k), e.pt);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [63:0] pt, input logic [127:0] k,
                         input logic [63:0] ct, input bit rt, input int extra,
                         input bit push);
        exp_t e;
        inBlock64 = pt;
        key       = k;
        start     = 1'b1;
        if (push) begin
            e.ct  = ct;
            e.cyc = cyc + 10 + extra;
            e.pt  = pt;
            e.k   = k;
            e.rt  = rt;
            sb.push_back(e);
            pushed++;
        end
        @(negedge clk);
        start     = 1'b0;
        inBlock64 = ~pt;
        key       = ~k;
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (busy === 1'b0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(name, done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0]  va, vb;
        logic [63:0]  b_pt, r_pt;
        logic [127:0] b_key, r_key;
        int           n;

        rst = 1'b1; ena = 1'b1; start = 1'b0; inBlock64 = '0; key = '0;
        repeat (3) @(negedge clk);
        chk("reset_out", outBlock64, 0);
        chk("reset_busy", busy, 0);
        chk("reset_valid", valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        va = 16'h0000; vb = 16'h0000; chk("mul_0_0",       cipher_pkg::idea_mul(va, vb), 16'h0001);
        va = 16'h0000; vb = 16'h0001; chk("mul_0_1",       cipher_pkg::idea_mul(va, vb), 16'h0000);
        va = 16'hFFFF; vb = 16'hFFFF; chk("mul_ffff_ffff", cipher_pkg::idea_mul(va, vb), 16'h0004);
        va = 16'h0000; vb = 16'h0002; chk("mul_0_2",       cipher_pkg::idea_mul(va, vb), 16'hFFFF);

        // Known answer, with busy counted over the whole operation.
        issue(KAT_PT, KAT_KEY, KAT_CT, 1'b1, 0, 1'b1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1) break;
            n++;
            @(negedge clk);
        end
        chk("kat_busy_cycles", n, 9);
        repeat (3) @(negedge clk);
        chk("out_held", outBlock64, KAT_CT);

        // Five frozen cycles in the middle of the rounds.
        issue(KAT_PT, KAT_KEY, KAT_CT, 1'b0, 5, 1'b1);
        repeat (3) @(negedge clk);
        ena = 1'b0;
        repeat (5) @(negedge clk);
        chk("frozen_busy", busy, 1);
        ena = 1'b1;
        wait_done("ena_done");

        // Start while busy is dropped; a start right after valid is taken.
        @(negedge clk);
        b_pt  = 64'h0123_4567_89AB_CDEF;
        b_key = 128'h2BD6_459F_82C5_B300_952C_4910_4881_FF48;
        issue(KAT_PT, KAT_KEY, KAT_CT, 1'b0, 0, 1'b1);
        repeat (3) @(negedge clk);
        inBlock64 = b_pt; key = b_key; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start_done");
        chk("valid_at_restart", valid, 1);
        issue(b_pt, b_key, m_enc(b_pt, b_key), 1'b1, 0, 1'b1);
        wait_done("second_block_done");

        // Reset in the middle of an operation.
        @(negedge clk);
        issue(KAT_PT, KAT_KEY, KAT_CT, 1'b0, 0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_out", outBlock64, 0);
        repeat (15) @(negedge clk);
        chk("abort_stays_idle", busy, 0);
        chk("abort_out_held", outBlock64, 0);
        issue(KAT_PT, KAT_KEY, KAT_CT, 1'b1, 0, 1'b1);
        wait_done("post_reset_done");

        // Random blocks, each also decrypted back by the model.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            r_pt  = {$urandom, $urandom};
            r_key = {$urandom, $urandom, $urandom, $urandom};
            issue(r_pt, r_key, m_enc(r_pt, r_key), 1'b1, 0, 1'b1);
            wait_done("random_done");
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("pulse_count", pulses, pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
